// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op, condition and state encodings for the ALU issue path
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_ORR = 4'b0011,
    OP_EOR = 4'b0100,
    OP_MOV = 4'b0101,
    OP_CMP = 4'b0110,
    OP_LDR = 4'b1000,
    OP_STR = 4'b1001,
    OP_LDM = 4'b1010,
    OP_BLX = 4'b1011
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM_WB,
    ST_LDM_RD,
    ST_LDM_WB,
    ST_HALT
  } state_e;

  // 0111 and the whole 11xx block are holes in the op map and behave as NOPs
  function automatic logic op_is_valid(input logic [3:0] op);
    return !((op == 4'b0111) || (op[3:2] == 2'b11));
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - ARM condition-code evaluator against an NZCV vector
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // Decode the condition field; NV (1111) never passes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multicycle issue controller driving the datapath ALU
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  instr_cond,
  input  logic [3:0]  instr_op,
  input  logic        instr_s,
  input  logic [3:0]  instr_rd,
  input  logic [15:0] instr_reglist,
  output logic [3:0]  alu_control,
  input  logic [3:0]  alu_flags,
  input  logic        alu_finished,
  output logic [5:0]  ldm_offset,
  output logic        reg_we,
  output logic [3:0]  reg_waddr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [3:0]  nzcv,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, rd_q;
  logic        s_q;
  logic [15:0] list_q, list_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  nzcv_d;
  logic [3:0]  ldm_idx;
  logic        accept;
  logic        cond_pass;

  cond_check u_cond_check (
    .cond (instr_cond),
    .nzcv (nzcv),
    .pass (cond_pass)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign halted      = (state_q == ST_HALT);

  // Priority encoder: lowest set bit of the remaining LDM register list
  always_comb begin
    ldm_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) ldm_idx = i[3:0];
    end
  end

  // Next-state, flag update and strobe generation
  always_comb begin
    state_d     = state_q;
    nzcv_d      = nzcv;
    list_d      = list_q;
    beat_d      = beat_q;
    alu_control = 4'b0000;
    reg_we      = 1'b0;
    reg_waddr   = 4'd0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    ldm_offset  = 6'd0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          list_d = instr_reglist;
          beat_d = 4'd0;
          if (cond_pass && op_is_valid(instr_op)) state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_control = op_q;
        state_d     = ST_IDLE;
        case (op_q)
          OP_ADD, OP_SUB: begin
            reg_we    = 1'b1;
            reg_waddr = rd_q;
            if (s_q) nzcv_d = alu_flags;
          end
          OP_AND, OP_ORR, OP_EOR, OP_MOV: begin
            reg_we    = 1'b1;
            reg_waddr = rd_q;
            // Logical ops have no meaningful carry/overflow, so C and V persist
            if (s_q) begin
              nzcv_d[FLAG_N] = alu_flags[FLAG_N];
              nzcv_d[FLAG_Z] = alu_flags[FLAG_Z];
            end
          end
          OP_CMP: nzcv_d = alu_flags;
          OP_LDR: begin
            mem_re  = 1'b1;
            state_d = ST_MEM_WB;
          end
          OP_STR: mem_we = 1'b1;
          OP_LDM: state_d = (list_q != 16'd0) ? ST_LDM_RD : ST_IDLE;
          OP_BLX: if (alu_finished) state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_MEM_WB: begin
        reg_we    = 1'b1;
        reg_waddr = rd_q;
        state_d   = ST_IDLE;
      end
      ST_LDM_RD: begin
        alu_control = OP_LDM;
        ldm_offset  = {beat_q, 2'b00};
        mem_re      = 1'b1;
        state_d     = ST_LDM_WB;
      end
      ST_LDM_WB: begin
        reg_we    = 1'b1;
        reg_waddr = ldm_idx;
        list_d    = list_q & ~(16'h0001 << ldm_idx);
        beat_d    = beat_q + 4'd1;
        state_d   = (list_d != 16'd0) ? ST_LDM_RD : ST_IDLE;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, architectural flags and LDM progress registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      nzcv    <= 4'b0000;
      list_q  <= 16'd0;
      beat_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      nzcv    <= nzcv_d;
      list_q  <= list_d;
      beat_q  <= beat_d;
    end
  end

  // Instruction field capture at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 4'd0;
      s_q  <= 1'b0;
      rd_q <= 4'd0;
    end else if (accept) begin
      op_q <= instr_op;
      s_q  <= instr_s;
      rd_q <= instr_rd;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_cond;
  logic [3:0]  instr_op;
  logic        instr_s;
  logic [3:0]  instr_rd;
  logic [15:0] instr_reglist;
  logic [3:0]  alu_control;
  logic [3:0]  alu_flags;
  logic        alu_finished;
  logic [5:0]  ldm_offset;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  nzcv;
  logic        halted;

  int passed = 0;
  int total  = 0;

  alu_issue_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_cond    (instr_cond),
    .instr_op      (instr_op),
    .instr_s       (instr_s),
    .instr_rd      (instr_rd),
    .instr_reglist (instr_reglist),
    .alu_control   (alu_control),
    .alu_flags     (alu_flags),
    .alu_finished  (alu_finished),
    .ldm_offset    (ldm_offset),
    .reg_we        (reg_we),
    .reg_waddr     (reg_waddr),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .nzcv          (nzcv),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one instruction at a negedge, let it be taken at the next posedge
  task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                       input logic [3:0] rd, input logic [15:0] list, input logic [3:0] flags);
    @(negedge clk);
    instr_valid   = 1'b1;
    instr_cond    = cond;
    instr_op      = op;
    instr_s       = s;
    instr_rd      = rd;
    instr_reglist = list;
    alu_flags     = flags;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_valid = 1'b1; instr_cond = 4'hE; instr_op = 4'h0; instr_s = 1'b1;
    instr_rd = 4'd1; instr_reglist = 16'h0; alu_flags = 4'hF; alu_finished = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({instr_ready, halted, nzcv} !== 6'b1_0_0000)
      $display("FAIL reset_status ready=%b halted=%b nzcv=%b want 1/0/0000", instr_ready, halted, nzcv);
    else passed++;
    total++;
    if ({reg_we, mem_re, mem_we, alu_control, reg_waddr, ldm_offset} !== 17'd0)
      $display("FAIL reset_outputs we=%b re=%b wr=%b ctl=%b waddr=%0d off=%0d want all 0",
               reg_we, mem_re, mem_we, alu_control, reg_waddr, ldm_offset);
    else passed++;
    instr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({instr_ready, reg_we, nzcv} !== 6'b1_0_0000)
      $display("FAIL reset_no_transfer ready=%b we=%b nzcv=%b want 1/0/0000", instr_ready, reg_we, nzcv);
    else passed++;
  endtask

  task automatic test_add_flags();
    issue(4'hE, 4'b0000, 1'b1, 4'd3, 16'h0, 4'b0110);
    @(negedge clk);
    total++;
    if ({instr_ready, reg_we, reg_waddr, alu_control, nzcv} !== {1'b0, 1'b1, 4'd3, 4'b0000, 4'b0000})
      $display("FAIL add_exec ready=%b we=%b waddr=%0d ctl=%b nzcv=%b want 0/1/3/0000/0000",
               instr_ready, reg_we, reg_waddr, alu_control, nzcv);
    else passed++;
    @(negedge clk);
    total++;
    if ({instr_ready, reg_we, nzcv} !== {1'b1, 1'b0, 4'b0110})
      $display("FAIL add_after ready=%b we=%b nzcv=%b want 1/0/0110", instr_ready, reg_we, nzcv);
    else passed++;
  endtask

  task automatic test_cmp_cond();
    issue(4'hE, 4'b0110, 1'b0, 4'd9, 16'h0, 4'b0100);
    @(negedge clk);
    total++;
    if ({alu_control, reg_we, instr_ready} !== {4'b0110, 1'b0, 1'b0})
      $display("FAIL cmp_exec ctl=%b we=%b ready=%b want 0110/0/0", alu_control, reg_we, instr_ready);
    else passed++;
    // MOV EQ accepted in the cycle right after the CMP's EXEC
    issue(4'b0000, 4'b0101, 1'b0, 4'd5, 16'h0, 4'b0000);
    total++;
    if (nzcv !== 4'b0100)
      $display("FAIL cmp_flags nzcv=%b want 0100", nzcv);
    else passed++;
    @(negedge clk);
    total++;
    if ({reg_we, reg_waddr, alu_control} !== {1'b1, 4'd5, 4'b0101})
      $display("FAIL mov_eq we=%b waddr=%0d ctl=%b want 1/5/0101", reg_we, reg_waddr, alu_control);
    else passed++;
    issue(4'b0001, 4'b0101, 1'b0, 4'd6, 16'h0, 4'b0000);
    @(negedge clk);
    total++;
    if ({reg_we, instr_ready, nzcv} !== {1'b0, 1'b1, 4'b0100})
      $display("FAIL mov_ne we=%b ready=%b nzcv=%b want 0/1/0100", reg_we, instr_ready, nzcv);
    else passed++;
  endtask

  task automatic test_logic_flags();
    issue(4'hE, 4'b0110, 1'b0, 4'd0, 16'h0, 4'b0011);
    @(negedge clk);
    issue(4'hE, 4'b0100, 1'b1, 4'd7, 16'h0, 4'b1000);
    total++;
    if (nzcv !== 4'b0011)
      $display("FAIL eor_pre nzcv=%b want 0011", nzcv);
    else passed++;
    @(negedge clk);
    total++;
    if ({reg_we, reg_waddr} !== {1'b1, 4'd7})
      $display("FAIL eor_wb we=%b waddr=%0d want 1/7", reg_we, reg_waddr);
    else passed++;
    @(negedge clk);
    total++;
    if (nzcv !== 4'b1011)
      $display("FAIL eor_flags nzcv=%b want 1011", nzcv);
    else passed++;
    // cond NV and a NOP opcode must both leave the controller idle
    issue(4'hF, 4'b0000, 1'b1, 4'd2, 16'h0, 4'b0000);
    @(negedge clk);
    total++;
    if ({reg_we, instr_ready, nzcv} !== {1'b0, 1'b1, 4'b1011})
      $display("FAIL cond_nv we=%b ready=%b nzcv=%b want 0/1/1011", reg_we, instr_ready, nzcv);
    else passed++;
    issue(4'hE, 4'b1101, 1'b1, 4'd2, 16'h0, 4'b0000);
    @(negedge clk);
    total++;
    if ({reg_we, mem_re, mem_we, instr_ready, alu_control} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'b0000})
      $display("FAIL nop we=%b re=%b wr=%b ready=%b ctl=%b want 0/0/0/1/0000",
               reg_we, mem_re, mem_we, instr_ready, alu_control);
    else passed++;
  endtask

  task automatic test_ldr_str();
    issue(4'hE, 4'b1000, 1'b1, 4'd9, 16'h0, 4'b1111);
    @(negedge clk);
    total++;
    if ({mem_re, reg_we, alu_control} !== {1'b1, 1'b0, 4'b1000})
      $display("FAIL ldr_exec re=%b we=%b ctl=%b want 1/0/1000", mem_re, reg_we, alu_control);
    else passed++;
    @(negedge clk);
    total++;
    if ({mem_re, reg_we, reg_waddr, instr_ready} !== {1'b0, 1'b1, 4'd9, 1'b0})
      $display("FAIL ldr_wb re=%b we=%b waddr=%0d ready=%b want 0/1/9/0", mem_re, reg_we, reg_waddr, instr_ready);
    else passed++;
    issue(4'hE, 4'b1001, 1'b1, 4'd4, 16'h0, 4'b1111);
    total++;
    if (instr_ready !== 1'b0)
      $display("FAIL str_accept ready=%b want 0", instr_ready);
    else passed++;
    @(negedge clk);
    total++;
    if ({mem_we, mem_re, reg_we, alu_control} !== {1'b1, 1'b0, 1'b0, 4'b1001})
      $display("FAIL str_exec wr=%b re=%b we=%b ctl=%b want 1/0/0/1001", mem_we, mem_re, reg_we, alu_control);
    else passed++;
    @(negedge clk);
    total++;
    if ({instr_ready, nzcv} !== {1'b1, 4'b1011})
      $display("FAIL ldr_str_flags ready=%b nzcv=%b want 1/1011", instr_ready, nzcv);
    else passed++;
  endtask

  task automatic test_ldm();
    // per busy cycle: ready, mem_re, reg_we, waddr (when writing), ldm_offset
    logic       e_re [8];
    logic       e_we [8];
    logic [3:0] e_wa [8];
    logic [5:0] e_of [8];
    logic [3:0] wa;
    e_re = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    e_we = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    e_wa = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd15, 4'd0};
    e_of = '{6'd0, 6'd0, 6'd0, 6'd4, 6'd0, 6'd8, 6'd0, 6'd0};
    issue(4'hE, 4'b1010, 1'b1, 4'd0, 16'h8005, 4'b0101);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wa = reg_we ? reg_waddr : 4'd0;
      total++;
      if ({instr_ready, mem_re, reg_we, wa, ldm_offset} !== {(c == 7), e_re[c], e_we[c], e_wa[c], e_of[c]})
        $display("FAIL ldm_cycle%0d ready=%b re=%b we=%b waddr=%0d off=%0d want %b/%b/%b/%0d/%0d",
                 c, instr_ready, mem_re, reg_we, wa, ldm_offset,
                 (c == 7), e_re[c], e_we[c], e_wa[c], e_of[c]);
      else passed++;
    end
    total++;
    if (nzcv !== 4'b1011)
      $display("FAIL ldm_flags nzcv=%b want 1011", nzcv);
    else passed++;
  endtask

  task automatic test_ldm_empty();
    issue(4'hE, 4'b1010, 1'b0, 4'd0, 16'h0000, 4'b0000);
    @(negedge clk);
    total++;
    if ({instr_ready, mem_re, alu_control} !== {1'b0, 1'b0, 4'b1010})
      $display("FAIL ldm_empty_exec ready=%b re=%b ctl=%b want 0/0/1010", instr_ready, mem_re, alu_control);
    else passed++;
    @(negedge clk);
    total++;
    if ({instr_ready, mem_re, reg_we} !== 3'b100)
      $display("FAIL ldm_empty_idle ready=%b re=%b we=%b want 1/0/0", instr_ready, mem_re, reg_we);
    else passed++;
  endtask

  task automatic test_blx_halt_reset();
    // BLX without completion falls back to IDLE
    issue(4'hE, 4'b1011, 1'b0, 4'd0, 16'h0, 4'b0000);
    @(negedge clk);
    total++;
    if (alu_control !== 4'b1011)
      $display("FAIL blx_ctl ctl=%b want 1011", alu_control);
    else passed++;
    @(negedge clk);
    total++;
    if ({halted, instr_ready} !== 2'b01)
      $display("FAIL blx_nofinish halted=%b ready=%b want 0/1", halted, instr_ready);
    else passed++;
    issue(4'hE, 4'b1011, 1'b0, 4'd0, 16'h0, 4'b0000);
    alu_finished = 1'b1;
    @(negedge clk);
    @(negedge clk);
    alu_finished = 1'b0;
    instr_valid = 1'b1; instr_cond = 4'hE; instr_op = 4'b0000; instr_rd = 4'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({halted, instr_ready, reg_we, mem_re, mem_we} !== 5'b10000)
        $display("FAIL halt_sticky%0d halted=%b ready=%b we=%b re=%b wr=%b want 1/0/0/0/0",
                 c, halted, instr_ready, reg_we, mem_re, mem_we);
      else passed++;
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({halted, instr_ready} !== 2'b01)
      $display("FAIL halt_cleared halted=%b ready=%b want 0/1", halted, instr_ready);
    else passed++;
    issue(4'hE, 4'b0110, 1'b0, 4'd0, 16'h0, 4'b1001);
    @(negedge clk);
    issue(4'hE, 4'b1010, 1'b0, 4'd0, 16'h0006, 4'b0000);
    repeat (4) @(negedge clk);
    total++;
    if ({mem_re, ldm_offset, nzcv} !== {1'b1, 6'd4, 4'b1001})
      $display("FAIL ldm2_beat1 re=%b off=%0d nzcv=%b want 1/4/1001", mem_re, ldm_offset, nzcv);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({reg_we, mem_re, instr_ready, nzcv} !== {1'b0, 1'b0, 1'b1, 4'b0000})
      $display("FAIL ldm_abort we=%b re=%b ready=%b nzcv=%b want 0/0/1/0000", reg_we, mem_re, instr_ready, nzcv);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({reg_we, mem_re, nzcv} !== 6'b0)
        $display("FAIL post_abort%0d we=%b re=%b nzcv=%b want 0/0/0000", c, reg_we, mem_re, nzcv);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_cmp_cond();
    test_logic_flags();
    test_ldr_str();
    test_ldm();
    test_ldm_empty();
    test_blx_halt_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
